// File: rtl/lif_tdm_scheduler_if.sv
// Bus bundle for the LIF time-multiplexed scheduler.
// The master side is the stimulus/current source plus the spike consumer and
// debug reader; the slave side is the scheduler itself.
interface lif_tdm_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int IDXW      = $clog2(N_NEURONS)
);
    // Timestep control
    logic            tick;
    logic            busy;
    logic            done;
    logic            overrun;

    // Current-write port
    logic            cur_valid;
    logic [IDXW-1:0] cur_idx;
    logic [7:0]      cur_data;
    logic            cur_ready;

    // Spike event stream
    logic            spike_valid;
    logic [IDXW-1:0] spike_idx;

    // Debug readback
    logic [IDXW-1:0] rd_idx;
    logic [7:0]      rd_state;

    modport master (
        output tick, cur_valid, cur_idx, cur_data, rd_idx,
        input  busy, done, overrun, cur_ready, spike_valid, spike_idx, rd_state
    );

    modport slave (
        input  tick, cur_valid, cur_idx, cur_data, rd_idx,
        output busy, done, overrun, cur_ready, spike_valid, spike_idx, rd_state
    );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Leaky-integrate-fire scheduler: one shared update datapath swept across
// N_NEURONS neurons, one neuron per clock, once per timestep tick.
// Membrane state and per-neuron input-current buffers live in flop arrays so
// the whole population can be cleared in a single reset cycle.
module lif_tdm_scheduler #(
    parameter int         N_NEURONS = 4,
    parameter logic [7:0] THRESHOLD = 8'd230
) (
    input  logic               clk,
    input  logic               rst_n,
    lif_tdm_scheduler_if.slave bus
);

    localparam int IDXW = $clog2(N_NEURONS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

    // Sweep controller encoding kept as plain constants for legacy tooling
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]      fsm;
    logic [IDXW-1:0] ptr;
    logic            sweeping;

    logic [7:0] state_mem [N_NEURONS];
    logic [7:0] cur_buf   [N_NEURONS];

    // Datapath for the neuron under the pointer
    logic [7:0] cur_s;
    logic [7:0] cur_c;
    logic       fire;
    logic [7:0] next_s;

    // Saturating accumulate for the current-write port
    logic       wr_en;
    logic [7:0] wr_old;
    logic [8:0] wr_sum;
    logic [7:0] wr_sat;

    // Registered outputs
    logic            spike_valid_r;
    logic [IDXW-1:0] spike_idx_r;
    logic            done_r;
    logic            overrun_r;

    assign sweeping = (fsm == ST_SWEEP);

    // LIF update for the neuron selected by ptr: leak by s*7/8 (three shifts), add current, or fire and reset
    // NOTE: every variable gets a default at the top of always_comb so no path can leave it unassigned and infer a latch.
    always_comb begin
        cur_s  = state_mem[ptr];
        cur_c  = cur_buf[ptr];
        fire   = (cur_s >= THRESHOLD);
        next_s = cur_c + (cur_s >> 1) + (cur_s >> 2) + (cur_s >> 3);
        if (fire) begin
            next_s = 8'd0;
        end
    end

    // Current-write accumulate, saturating at 255; out-of-range indices are dropped
    always_comb begin
        wr_en  = bus.cur_valid && (int'(bus.cur_idx) < N_NEURONS);
        wr_old = 8'd0;
        if (wr_en) begin
            wr_old = cur_buf[bus.cur_idx];
        end
        wr_sum = {1'b0, wr_old} + {1'b0, bus.cur_data};
        wr_sat = wr_sum[8] ? 8'hFF : wr_sum[7:0];
    end

    // Sweep sequencing, spike/done strobes and the sticky overrun flag
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm           <= ST_IDLE;
            ptr           <= '0;
            spike_valid_r <= 1'b0;
            spike_idx_r   <= '0;
            done_r        <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            spike_valid_r <= sweeping && fire;
            if (sweeping && fire) begin
                spike_idx_r <= ptr;
            end
            done_r <= sweeping && (ptr == LAST_IDX);
            if (bus.tick && (fsm != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end

            case (fsm)
                ST_IDLE: begin
                    if (bus.tick) begin
                        fsm <= ST_SWEEP;
                        ptr <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (ptr == LAST_IDX) begin
                        fsm <= ST_DONE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_DONE: begin
                    fsm <= ST_IDLE;
                    ptr <= '0;
                end
                default: begin
                    fsm <= ST_IDLE;
                    ptr <= '0;
                end
            endcase
        end
    end

    // Membrane state: only the neuron under the pointer changes, and only during a sweep
    // NOTE: the arrays are reset explicitly because a reset must clear every neuron in one cycle; this keeps them in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_NEURONS; j++) begin
                state_mem[j] <= 8'd0;
            end
        end else if (sweeping) begin
            state_mem[ptr] <= next_s;
        end
    end

    // Input-current buffers: accumulate writes, clear on processing; a write that
    // collides with processing replaces the buffer so it counts toward the next step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_NEURONS; j++) begin
                cur_buf[j] <= 8'd0;
            end
        end else begin
            for (int j = 0; j < N_NEURONS; j++) begin
                if (wr_en && (bus.cur_idx == IDXW'(j))) begin
                    if (sweeping && (ptr == IDXW'(j))) begin
                        cur_buf[j] <= bus.cur_data;
                    end else begin
                        cur_buf[j] <= wr_sat;
                    end
                end else if (sweeping && (ptr == IDXW'(j))) begin
                    cur_buf[j] <= 8'd0;
                end
            end
        end
    end

    // Debug readback is a plain mux; out-of-range selects read as zero
    always_comb begin
        bus.rd_state = 8'd0;
        if (int'(bus.rd_idx) < N_NEURONS) begin
            bus.rd_state = state_mem[bus.rd_idx];
        end
    end

    assign bus.cur_ready   = rst_n;
    assign bus.busy        = (fsm != ST_IDLE);
    assign bus.done        = done_r;
    assign bus.overrun     = overrun_r;
    assign bus.spike_valid = spike_valid_r;
    assign bus.spike_idx   = spike_idx_r;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench for lif_tdm_scheduler (N_NEURONS=4, THRESHOLD=230).
// Expected spike and done events are queued with their cycle numbers when a
// tick is issued; a negedge monitor pops and compares whatever the DUT emits.
`timescale 1ns/1ps
module tb_lif_tdm_scheduler;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    lif_tdm_scheduler_if #(.N_NEURONS(N)) bus ();

    lif_tdm_scheduler #(
        .N_NEURONS (N),
        .THRESHOLD (8'd230)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int idx;
    } ev_t;

    ev_t spike_q[$];
    int  done_q[$];
    ev_t mon_e;
    int  mon_c;

    int cyc     = 0;
    int tests   = 0;
    int fails   = 0;
    int t_start = 0;

    int t2_exp [6] = '{60, 112, 158, 197, 231, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every emitted spike/done must match the head of its queue
    always @(negedge clk) begin
        if (bus.spike_valid === 1'b1) begin
            if (spike_q.size() == 0) begin
                check("spike_unexpected", int'(bus.spike_valid), 0);
            end else begin
                mon_e = spike_q.pop_front();
                check("spike_cycle", cyc, mon_e.cyc);
                check("spike_idx", int'(bus.spike_idx), mon_e.idx);
            end
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", int'(bus.done), 0);
            end else begin
                mon_c = done_q.pop_front();
                check("done_cycle", cyc, mon_c);
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cur(input int idx, input int data);
        bus.cur_valid = 1'b1;
        bus.cur_idx   = IDXW'(idx);
        bus.cur_data  = 8'(data);
        idle_cycle();
        bus.cur_valid = 1'b0;
    endtask

    // Drives tick for one cycle (cycle T) and queues spikes at T+2+i and done at T+N+1
    task automatic start_tick(input logic [N-1:0] mask, input bit expect_events);
        bus.tick = 1'b1;
        t_start  = cyc;
        if (expect_events) begin
            for (int i = 0; i < N; i++) begin
                if (mask[i]) spike_q.push_back('{t_start + 2 + i, i});
            end
            done_q.push_back(t_start + N + 1);
        end
        idle_cycle();
        bus.tick = 1'b0;
    endtask

    task automatic finish_sweep();
        while (cyc < t_start + N + 2) idle_cycle();
        check("idle_after_sweep", int'(bus.busy), 0);
    endtask

    task automatic check_state(input string name, input int idx, input int exp);
        bus.rd_idx = IDXW'(idx);
        #1;
        check(name, int'(bus.rd_state), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick      = 1'b0;
        bus.cur_valid = 1'b0;
        bus.cur_idx   = '0;
        bus.cur_data  = '0;
        bus.rd_idx    = '0;
        rst_n         = 1'b0;
        repeat (3) idle_cycle();

        // Reset state
        check("rst_cur_ready", int'(bus.cur_ready), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_spike_valid", int'(bus.spike_valid), 0);
        check("rst_spike_idx", int'(bus.spike_idx), 0);
        for (int i = 0; i < N; i++) check_state("rst_state", i, 0);
        rst_n = 1'b1;
        idle_cycle();
        check("cur_ready_out_of_reset", int'(bus.cur_ready), 1);

        // 1) Single current into n0, one sweep
        write_cur(0, 100);
        start_tick(4'b0000, 1'b1);
        check("t1_busy_in_sweep", int'(bus.busy), 1);
        idle_cycle();
        check_state("t1_state0_after_n0", 0, 100);
        finish_sweep();
        check("t1_overrun", int'(bus.overrun), 0);

        // 2) n1 driven with 60 per step until it crosses threshold and fires
        for (int k = 0; k < 6; k++) begin
            write_cur(1, 60);
            start_tick((k == 5) ? 4'b0010 : 4'b0000, 1'b1);
            finish_sweep();
            check_state("t2_state1", 1, t2_exp[k]);
        end
        check_state("t2_state0_leak", 0, 42);

        // 3) Saturating buffer: 200 + 100 clamps at 255, then fires next step
        write_cur(2, 200);
        write_cur(2, 100);
        start_tick(4'b0000, 1'b1);
        finish_sweep();
        check_state("t3_state2_sat", 2, 255);
        check_state("t3_state0", 0, 36);
        start_tick(4'b0100, 1'b1);
        finish_sweep();
        check_state("t3_state2_fired", 2, 0);
        check_state("t3_state0_b", 0, 31);

        // 4) Write to n3 in the exact cycle n3 is processed (T+4)
        write_cur(3, 50);
        start_tick(4'b0000, 1'b1);
        repeat (3) idle_cycle();
        bus.cur_valid = 1'b1;
        bus.cur_idx   = 2'd3;
        bus.cur_data  = 8'd77;
        idle_cycle();
        bus.cur_valid = 1'b0;
        finish_sweep();
        check_state("t4_state3_old_buf", 3, 50);
        check_state("t4_state0", 0, 25);
        start_tick(4'b0000, 1'b1);
        finish_sweep();
        check_state("t4_state3_new_buf", 3, 120);
        check_state("t4_state0_b", 0, 21);

        // 5) Ticks at T+2 (SWEEP) and T+N+1 (DONE) are ignored and set overrun
        check("t5_overrun_before", int'(bus.overrun), 0);
        start_tick(4'b0000, 1'b1);
        idle_cycle();
        bus.tick = 1'b1;
        idle_cycle();
        bus.tick = 1'b0;
        while (cyc < t_start + N + 1) idle_cycle();
        bus.tick = 1'b1;
        idle_cycle();
        bus.tick = 1'b0;
        check("t5_overrun_set", int'(bus.overrun), 1);
        check("t5_idle", int'(bus.busy), 0);
        check_state("t5_state0", 0, 17);
        check_state("t5_state3", 3, 105);
        start_tick(4'b0000, 1'b1);
        finish_sweep();
        check("t5_overrun_sticky", int'(bus.overrun), 1);
        check_state("t5_state0_b", 0, 14);
        check_state("t5_state3_b", 3, 91);

        // 6) Reset mid-sweep: no done, no spike, everything cleared
        write_cur(2, 30);
        start_tick(4'b0000, 1'b0);
        idle_cycle();
        rst_n = 1'b0;
        idle_cycle();
        check("t6_busy", int'(bus.busy), 0);
        check("t6_done", int'(bus.done), 0);
        check("t6_spike_valid", int'(bus.spike_valid), 0);
        check("t6_overrun", int'(bus.overrun), 0);
        check("t6_cur_ready", int'(bus.cur_ready), 0);
        for (int i = 0; i < N; i++) check_state("t6_state", i, 0);
        rst_n = 1'b1;
        repeat (N + 2) idle_cycle();
        start_tick(4'b0000, 1'b1);
        finish_sweep();
        check_state("t6_state2_buf_cleared", 2, 0);
        check("t6_overrun_after", int'(bus.overrun), 0);

        repeat (2) idle_cycle();
        check("spike_queue_drained", spike_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
